spi_master_p: RTL

SPI_MASTER_P -- requirements
Module: spi_master_p

---
 rtl/spi_master_p.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_p.sv
// SPI master with programmable SCLK divider, CPOL/CPHA, 8/16/32-bit frames
// and optional slave-select hold across consecutive transfers.
module spi_master_p #(
    parameter int NCS  = 4,
    parameter int DIVW = 8,
    localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      len,
    input  logic [1:0]      mode,
    input  logic [DIVW-1:0] div,
    input  logic [CSW-1:0]  csel,
    input  logic            csHold,
    input  logic [31:0]     dataTx,
    output logic [31:0]     dataRx,
    output logic            rdy,
    input  logic            MISO,
    output logic            MOSI,
    output logic            SCLK,
    output logic [NCS-1:0]  SS_n
);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

    state_e          state_q, state_d;
    logic [1:0]      len_q, len_d;
    logic            cpol_q, cpol_d;
    logic            cpha_q, cpha_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            hold_q, hold_d;
    logic [31:0]     tx_q, tx_d;
    logic [31:0]     rx_q, rx_d;
    logic [DIVW-1:0] hp_q, hp_d;
    logic [5:0]      h_q, h_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [NCS-1:0]  ss_n_q, ss_n_d;
    logic [31:0]     data_rx_q, data_rx_d;

    logic            hp_end;
    logic [5:0]      last_h;
    logic [31:0]     tx_seq;
    logic [31:0]     rx_word;
    logic            edge_now;
    logic            edge_lead;

    // Bytes go out LSByte first, MSbit first: pre-order so bit 31 is always next.
    assign tx_seq = {dataTx[7:0], dataTx[15:8], dataTx[23:16], dataTx[31:24]};
    assign hp_end = (hp_q == div_q);

    always_comb begin
        last_h = 6'd63;
        case (len_q)
            2'b00:   last_h = 6'd15;
            2'b01:   last_h = 6'd31;
            default: last_h = 6'd63;
        endcase
    end

    always_comb begin
        rx_word = '0;
        case (len_q)
            2'b00:   rx_word = {24'd0, rx_q[7:0]};
            2'b01:   rx_word = {16'd0, rx_q[7:0], rx_q[15:8]};
            default: rx_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        div_d     = div_q;
        hold_d    = hold_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        hp_d      = hp_q;
        h_d       = h_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        data_rx_d = data_rx_q;
        edge_now  = 1'b0;
        edge_lead = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol_q;
                mosi_d = 1'b1;
                if (start) begin
                    state_d = LEAD;
                    len_d   = len;
                    cpol_d  = mode[1];
                    cpha_d  = mode[0];
                    div_d   = div;
                    hold_d  = csHold;
                    hp_d    = '0;
                    h_d     = '0;
                    rx_d    = '0;
                    sclk_d  = mode[1];
                    if (mode[0]) begin
                        tx_d = tx_seq;
                    end else begin
                        mosi_d = tx_seq[31];
                        tx_d   = {tx_seq[30:0], 1'b1};
                    end
                    ss_n_d = '1;
                    if (int'(csel) < NCS) ss_n_d[csel] = 1'b0;
                end
            end
            LEAD: begin
                if (hp_end) begin
                    hp_d      = '0;
                    state_d   = SHIFT;
                    edge_now  = 1'b1;
                    edge_lead = 1'b1;
                end else begin
                    hp_d = hp_q + 1'b1;
                end
            end
            SHIFT: begin
                // Entering half-period h+1: even index is a leading SCLK edge.
                if (hp_end) begin
                    hp_d = '0;
                    if (h_q == last_h) begin
                        state_d = TRAIL;
                    end else begin
                        h_d       = h_q + 6'd1;
                        edge_now  = 1'b1;
                        edge_lead = h_q[0];
                    end
                end else begin
                    hp_d = hp_q + 1'b1;
                end
            end
            TRAIL: begin
                if (hp_end) begin
                    hp_d      = '0;
                    state_d   = IDLE;
                    mosi_d    = 1'b1;
                    data_rx_d = rx_word;
                    if (!hold_q) ss_n_d = '1;
                end else begin
                    hp_d = hp_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (edge_now) begin
            sclk_d = ~sclk_q;
            if (edge_lead ^ cpha_q) begin
                rx_d = {rx_q[30:0], MISO};
            end else begin
                mosi_d = tx_q[31];
                tx_d   = {tx_q[30:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            hold_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            hp_q      <= '0;
            h_q       <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            ss_n_q    <= '1;
            data_rx_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            hp_q      <= hp_d;
            h_q       <= h_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            data_rx_q <= data_rx_d;
        end
    end

    assign rdy    = (state_q == IDLE);
    assign dataRx = data_rx_q;
    assign MOSI   = mosi_q;
    assign SCLK   = sclk_q;
    assign SS_n   = ss_n_q;

endmodule
